// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - frame accumulator with a carry-save running sum and a one-cycle resolve stage
// Beats are folded into S/C with 3:2 compression; a single adder resolves S+C once per frame.
module csa_accumulator #(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 12,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_overflow,
  output logic [CNT_WIDTH-1:0] out_count
);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_RESOLVE = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] s_q, s_d;
  logic [ACC_WIDTH-1:0] c_q, c_d;
  logic                 sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                 out_ovf_q, out_ovf_d;
  logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;

  logic [ACC_WIDTH-1:0] operand;
  logic [ACC_WIDTH-1:0] col_sum;
  logic [ACC_WIDTH-1:0] col_carry;
  logic [ACC_WIDTH:0]   resolved;
  logic                 accept;
  logic                 release_out;

  assign in_ready    = (state_q == ST_ACCUM) && !rst;
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == ST_OUTPUT) && !rst;
  assign release_out = out_valid && out_ready;

  // Result registers are masked during reset so nothing stale leaks out before the first edge.
  assign out_sum      = rst ? '0   : out_sum_q;
  assign out_overflow = rst ? 1'b0 : out_ovf_q;
  assign out_count    = rst ? '0   : out_cnt_q;

  always_comb begin
    operand                = '0;
    operand[IN_WIDTH-1:0]  = in_data;
    col_sum                = s_q ^ c_q ^ operand;
    col_carry              = (s_q & c_q) | (s_q & operand) | (c_q & operand);
    resolved               = {1'b0, s_q} + {1'b0, c_q};
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    c_d       = c_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          s_d = col_sum;
          // Top-column carry has no home in C; it is a guaranteed 2^ACC_WIDTH contribution.
          c_d      = col_carry << 1;
          sticky_d = sticky_q | col_carry[ACC_WIDTH-1];
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
          if (in_last) begin
            state_d = ST_RESOLVE;
          end
        end
      end
      ST_RESOLVE: begin
        out_sum_d = resolved[ACC_WIDTH-1:0];
        out_ovf_d = sticky_q | resolved[ACC_WIDTH];
        out_cnt_d = cnt_q;
        state_d   = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (release_out) begin
          state_d  = ST_ACCUM;
          s_d      = '0;
          c_d      = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d  = ST_ACCUM;
        s_d      = '0;
        c_d      = '0;
        sticky_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      s_q       <= '0;
      c_q       <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      c_q       <= c_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - scoreboard bench for csa_accumulator with an integer-sum reference model
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        out_overflow;
  logic [3:0]  out_count;

  csa_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] sum;
    logic        ovf;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_expected = 0;
  int   n_results = 0;
  int   ready_mode = 0;
  int   acc_sum = 0;
  int   acc_n = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer sum of the frame, reduced only when the result is reported.
  task automatic model_accept(input int d, input bit last);
    exp_t e;
    acc_sum += d;
    acc_n++;
    if (last) begin
      e.sum = 12'(acc_sum % 4096);
      e.ovf = (acc_sum >= 4096);
      e.cnt = (acc_n > 15) ? 4'd15 : 4'(acc_n);
      exp_q.push_back(e);
      n_expected++;
      acc_sum = 0;
      acc_n   = 0;
    end
  endtask

  // Entered and left at posedge+#1; returns after the edge that accepted the beat.
  task automatic send_beat(input int d, input bit last, input int stall_pct);
    bit done = 0;
    int guard = 0;
    while (!done) begin
      in_valid = ($urandom_range(0, 99) >= stall_pct);
      in_data  = in_valid ? 8'(d) : 8'($urandom);
      in_last  = in_valid ? last : 1'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) begin
        done = 1;
        model_accept(d, last);
      end
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 300) begin
        check("beat_accept_timeout", 0, 1);
        done = 1;
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_timeout", (guard >= 500), 0);
    in_valid = 1'b0;
  endtask

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 99) < 60);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops on every delivered result and enforces hold-stability while stalled.
  bit          hold_pending = 0;
  logic [11:0] h_sum;
  logic        h_ovf;
  logic [3:0]  h_cnt;
  always begin
    exp_t e;
    @(negedge clk);
    if (out_valid) begin
      check("in_ready_while_out_valid", in_ready, 0);
      if (hold_pending) begin
        check("hold_sum", out_sum, h_sum);
        check("hold_ovf", out_overflow, h_ovf);
        check("hold_cnt", out_count, h_cnt);
      end
      if (out_ready) begin
        n_results++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_sum", out_sum, e.sum);
          check("out_overflow", out_overflow, e.ovf);
          check("out_count", out_count, e.cnt);
        end
      end
    end
    hold_pending = out_valid && !out_ready;
    h_sum = out_sum;
    h_ovf = out_overflow;
    h_cnt = out_count;
  end

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_overflow", out_overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // 10,20,30 with fixed latency: RESOLVE cycle, then OUTPUT.
    ready_mode = 0;
    send_beat(10, 0, 0);
    send_beat(20, 0, 0);
    send_beat(30, 1, 0);
    @(negedge clk);
    check("lat_resolve_valid", out_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_output_valid", out_valid, 1);
    check("lat_out_sum", out_sum, 60);
    @(posedge clk);
    #1;
    drain();

    // 17 x 255: overflow and saturated count.
    for (int i = 0; i < 17; i++) send_beat(255, (i == 16), 0);
    drain();

    // Single beat held by out_ready=0.
    ready_mode = 2;
    send_beat(255, 1, 0);
    @(posedge clk);
    #1;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_sum_255", out_sum, 255);
      check("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    ready_mode = 0;
    drain();

    // Back-to-back {1,2} and {3} with in_valid held high.
    send_beat(1, 0, 0);
    send_beat(2, 1, 0);
    send_beat(3, 1, 0);
    drain();

    // Abort mid-frame after two beats, then {5}.
    send_beat(40, 0, 0);
    send_beat(50, 0, 0);
    rst = 1'b1;
    acc_sum = 0;
    acc_n   = 0;
    @(negedge clk);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_beat(5, 1, 0);
    drain();

    // Abort with a result waiting in OUTPUT.
    ready_mode = 2;
    send_beat(66, 1, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_abort_valid", out_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    n_expected--;
    @(negedge clk);
    check("abort_out_valid_held", out_valid, 0);
    check("abort_out_sum_held", out_sum, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    send_beat(7, 1, 0);
    drain();

    // Random frames with input and output stalls.
    ready_mode = 1;
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(1, 40);
      for (int b = 0; b < n; b++) begin
        send_beat((f % 5 == 0) ? $urandom_range(200, 255) : $urandom_range(0, 255), (b == n - 1), 30);
      end
    end
    in_valid = 1'b0;
    drain();
    check("result_count", n_results, n_expected);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
